fifo_state_ctrl: RTL and testbench

Sequential control stage for the 8-entry FIFO. It samples the write and read requests each clock, decides and registers the FIFO operation state, and maintains the head, tail and data_count registers. It generates the registered write/read strobes and addresses for the storage array and drives the status/handshake flags. The datapath register file consumes its we/re/addr outputs directly.

---
 rtl/fifo_state_ctrl_if.sv | 45 ++++
 rtl/fifo_state_ctrl.sv | 101 ++++++++++
 tb/tb_fifo_state_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_state_ctrl_if.sv
// rtl/fifo_state_ctrl_if.sv - request/status bundle between the FIFO user and fifo_state_ctrl.
// Carries almost_full/almost_empty only when FIFO_ALMOST_FLAGS_EN is defined.
interface fifo_state_ctrl_if #(
  parameter int AW = 3,
  parameter int CW = 4
);
  logic          wr_en;
  logic          rd_en;
  logic [2:0]    state;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] data_count;
  logic          we;
  logic          re;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          full;
  logic          empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
`ifdef FIFO_ALMOST_FLAGS_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  modport master (
    output wr_en, rd_en,
    input  state, head, tail, data_count, we, re, wr_addr, rd_addr,
           full, empty, wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
           , almost_full, almost_empty
`endif
  );

  modport slave (
    input  wr_en, rd_en,
    output state, head, tail, data_count, we, re, wr_addr, rd_addr,
           full, empty, wr_ack, wr_err, rd_ack, rd_err
`ifdef FIFO_ALMOST_FLAGS_EN
           , almost_full, almost_empty
`endif
  );
endinterface

// File: rtl/fifo_state_ctrl.sv
// rtl/fifo_state_ctrl.sv - FIFO control stage: op state, head/tail/count, storage strobes and flags.
// Optional almost_full/almost_empty outputs enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo_state_ctrl #(
  parameter int AW = 3,
  parameter int CW = 4
) (
  input logic             clk,
  input logic             reset,
  fifo_state_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_WR_ERROR = 3'b010,
    ST_READ     = 3'b011,
    ST_RD_ERROR = 3'b100,
    ST_NO_OP    = 3'b101
  } state_t;

  localparam logic [CW-1:0] DEPTH = CW'(2 ** AW);

  state_t        r_state;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_we;
  logic          r_re;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_rd_addr;

  logic w_full;
  logic w_empty;

  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == '0);

  // The decision depends only on the requests and the count, so any state
  // code (including unused ones) leads to the same next-state choice.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_we      <= 1'b0;
      r_re      <= 1'b0;
      r_wr_addr <= '0;
      r_rd_addr <= '0;
    end else begin
      r_we <= 1'b0;
      r_re <= 1'b0;
      case ({bus.wr_en, bus.rd_en})
        2'b10: begin
          if (!w_full) begin
            r_state   <= ST_WRITE;
            r_wr_addr <= r_tail;
            r_tail    <= r_tail + 1'b1;
            r_count   <= r_count + 1'b1;
            r_we      <= 1'b1;
          end else begin
            r_state <= ST_WR_ERROR;
          end
        end
        2'b01: begin
          if (!w_empty) begin
            r_state   <= ST_READ;
            r_rd_addr <= r_head;
            r_head    <= r_head + 1'b1;
            r_count   <= r_count - 1'b1;
            r_re      <= 1'b1;
          end else begin
            r_state <= ST_RD_ERROR;
          end
        end
        default: r_state <= ST_NO_OP;
      endcase
    end
  end

  assign bus.state      = r_state;
  assign bus.head       = r_head;
  assign bus.tail       = r_tail;
  assign bus.data_count = r_count;
  assign bus.we         = r_we;
  assign bus.re         = r_re;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.wr_ack     = (r_state == ST_WRITE);
  assign bus.wr_err     = (r_state == ST_WR_ERROR);
  assign bus.rd_ack     = (r_state == ST_READ);
  assign bus.rd_err     = (r_state == ST_RD_ERROR);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign bus.almost_full  = !reset && (r_count == DEPTH - 1'b1);
  assign bus.almost_empty = !reset && (r_count == CW'(1));
`endif

endmodule

// File: tb/tb_fifo_state_ctrl.sv
// tb/tb_fifo_state_ctrl.sv - self-checking bench for fifo_state_ctrl with a queue-based reference model.
module tb_fifo_state_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic wr_en;
  logic rd_en;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_state_ctrl_if #(.AW(3), .CW(4)) bus ();

  assign bus.wr_en = wr_en;
  assign bus.rd_en = rd_en;

  fifo_state_ctrl #(.AW(3), .CW(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO occupancy is the set of written slot addresses.
  int m_q[$];
  int m_head, m_tail, m_state, m_wa, m_ra;
  bit m_we, m_re, m_valid;

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_head = 0; m_tail = 0; m_state = 0;
        m_wa = 0; m_ra = 0; m_we = 0; m_re = 0;
        m_valid = 1;
      end else begin
        m_we = 0;
        m_re = 0;
        if (wr_en && !rd_en) begin
          if (m_q.size() < 8) begin
            m_state = 1; m_wa = m_tail; m_we = 1;
            m_q.push_back(m_tail);
            m_tail = (m_tail + 1) % 8;
          end else m_state = 2;
        end else if (rd_en && !wr_en) begin
          if (m_q.size() > 0) begin
            m_state = 3; m_re = 1;
            m_ra = m_q.pop_front();
            m_head = (m_head + 1) % 8;
          end else m_state = 4;
        end else m_state = 5;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("state", bus.state, m_state);
        chk("head", bus.head, m_head);
        chk("tail", bus.tail, m_tail);
        chk("data_count", bus.data_count, m_q.size());
        chk("we", bus.we, m_we);
        chk("re", bus.re, m_re);
        chk("wr_addr", bus.wr_addr, m_wa);
        chk("rd_addr", bus.rd_addr, m_ra);
        chk("full", bus.full, m_q.size() == 8);
        chk("empty", bus.empty, m_q.size() == 0);
        chk("wr_ack", bus.wr_ack, m_state == 1);
        chk("wr_err", bus.wr_err, m_state == 2);
        chk("rd_ack", bus.rd_ack, m_state == 3);
        chk("rd_err", bus.rd_err, m_state == 4);
        chk("we_re_excl", bus.we & bus.re, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
        chk("almost_full", bus.almost_full, !reset && m_q.size() == 7);
        chk("almost_empty", bus.almost_empty, !reset && m_q.size() == 1);
`endif
      end
    end
  end

  // Inputs change 2 time units after a rising edge; returns at the same point after the next edge.
  task automatic step(input logic w, input logic r, input logic rs);
    wr_en = w;
    rd_en = r;
    reset = rs;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #2;
    step(0, 0, 1);
    chk("rst_state", bus.state, 0);
    chk("rst_head", bus.head, 0);
    chk("rst_tail", bus.tail, 0);
    chk("rst_count", bus.data_count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_re", bus.re, 0);

    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0);
      chk("fill_state", bus.state, 1);
      chk("fill_wr_addr", bus.wr_addr, i);
      chk("fill_count", bus.data_count, i + 1);
    end
    chk("fill_full", bus.full, 1);
    step(1, 0, 0);
    chk("ovf_state", bus.state, 2);
    chk("ovf_wr_err", bus.wr_err, 1);
    chk("ovf_tail", bus.tail, 0);
    chk("ovf_count", bus.data_count, 8);

    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      chk("drain_rd_addr", bus.rd_addr, i);
      chk("drain_count", bus.data_count, 7 - i);
    end
    chk("drain_empty", bus.empty, 1);
    step(0, 1, 0);
    chk("udf_state", bus.state, 4);
    chk("udf_rd_err", bus.rd_err, 1);
    chk("udf_head", bus.head, 0);

    for (int i = 0; i < 6; i++) step(1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0);
      chk("wrap_wr_addr", bus.wr_addr, (6 + i) % 8);
    end
    chk("wrap_tail", bus.tail, 2);
    chk("wrap_head", bus.head, 6);
    chk("wrap_count", bus.data_count, 4);

    step(0, 1, 0);
    step(1, 1, 0);
    chk("both_state", bus.state, 5);
    chk("both_we", bus.we, 0);
    chk("both_re", bus.re, 0);
    chk("both_count", bus.data_count, 3);
    chk("both_head", bus.head, 7);
    chk("both_tail", bus.tail, 2);
    step(0, 0, 0);
    chk("idle_state", bus.state, 5);
    chk("idle_count", bus.data_count, 3);

    step(1, 0, 0);
    step(1, 0, 0);
    chk("mid_pre_state", bus.state, 1);
    chk("mid_pre_count", bus.data_count, 5);
    step(1, 0, 1);
    chk("mid_state", bus.state, 0);
    chk("mid_count", bus.data_count, 0);
    chk("mid_we", bus.we, 0);
    chk("mid_tail", bus.tail, 0);

    for (int i = 0; i < 7; i++) step(1, 0, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("af_at7", bus.almost_full, 1);
`endif
    chk("count7", bus.data_count, 7);
    for (int i = 0; i < 6; i++) step(0, 1, 0);
`ifdef FIFO_ALMOST_FLAGS_EN
    chk("ae_at1", bus.almost_empty, 1);
`endif
    chk("count1", bus.data_count, 1);
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
